led_register_viewer: RTL and testbench

LED_REGISTER_VIEWER -- requirements
Module: led_register_viewer

---
 rtl/led_viewer_pkg.sv | 22 ++
 rtl/led_register_viewer_btn_debounce.sv | 57 +++++
 rtl/led_register_viewer.sv | 189 ++++++++++++++++++
 tb/tb_led_register_viewer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/led_viewer_pkg.sv
// Shared definitions for the LED register viewer.
// Holds the display-mode FSM encoding and the helpers that derive the
// slice count and slice-index width from the data and LED widths.
package led_viewer_pkg;

  typedef enum logic [0:0] {
    StManual = 1'b0,
    StAuto   = 1'b1
  } view_state_e;

  // Number of LED-wide slices needed to cover a data word (ceiling divide).
  function automatic int unsigned calc_num_slices(input int unsigned data_w,
                                                  input int unsigned led_w);
    return (data_w + led_w - 1) / led_w;
  endfunction

  // Width of a slice index; never narrower than one bit.
  function automatic int unsigned calc_sl_w(input int unsigned num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/led_register_viewer_btn_debounce.sv
// btn_debounce: two-flop synchronizer plus level debouncer for a raw pushbutton.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   btn         - raw, bouncy button input
//   level       - debounced level; changes only after DEBOUNCE_CYCLES consecutive
//                 cycles of the new synchronized level
//   rise        - one-cycle pulse, registered together with the rising level
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic            rise_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      cnt_q   <= cnt_d;
    end
  end

  // Count cycles where the synchronized input differs from the debounced level;
  // any cycle that agrees clears the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntMax) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/led_register_viewer.sv
// led_register_viewer: shows one LED-wide slice of a processor register on an
// LED bank, either chosen by switches (manual) or stepped automatically through
// all slices of all registers (auto-scroll). A debounced button freezes a
// snapshot of the current register so it can be browsed while the core runs on.
// Ports:
//   clk, reset  - clock, asynchronous active-low reset
//   sw_reg      - manual register select (raw switch)
//   sw_slice    - manual slice select (raw switch)
//   sw_mode     - 0 = manual, 1 = auto-scroll (raw switch)
//   btn_freeze  - raw freeze pushbutton; each debounced press toggles freeze
//   reg_addr    - debug read address to the register file
//   reg_data    - combinational read data for reg_addr
//   leds        - displayed slice
//   frozen      - snapshot is being displayed
//   slice_idx   - slice currently selected
module led_register_viewer
  import led_viewer_pkg::*;
#(
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned LED_W           = 16,
  parameter int unsigned REG_ADDR_W      = 4,
  parameter int unsigned SCROLL_DIV      = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  localparam int unsigned NUM_SLICES     = calc_num_slices(DATA_W, LED_W),
  localparam int unsigned SL_W           = calc_sl_w(NUM_SLICES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] sw_reg,
  input  logic [SL_W-1:0]       sw_slice,
  input  logic                  sw_mode,
  input  logic                  btn_freeze,
  output logic [REG_ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0]     reg_data,
  output logic [LED_W-1:0]      leds,
  output logic                  frozen,
  output logic [SL_W-1:0]       slice_idx
);

  localparam int unsigned PadW   = NUM_SLICES * LED_W;
  localparam int unsigned SwW    = REG_ADDR_W + SL_W + 1;
  localparam int unsigned PrescW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [PrescW-1:0] PrescMax  = PrescW'(SCROLL_DIV - 1);
  localparam logic [SL_W-1:0]   LastSlice = SL_W'(NUM_SLICES - 1);

  // Switch synchronizers (no debouncing; a bounce just shows briefly on the LEDs).
  logic [SwW-1:0]        sw_s1_q, sw_s2_q;
  logic [REG_ADDR_W-1:0] sw_reg_s;
  logic [SL_W-1:0]       sw_slice_s;
  logic                  sw_mode_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= {sw_reg, sw_slice, sw_mode};
      sw_s2_q <= sw_s1_q;
    end
  end

  assign sw_reg_s   = sw_s2_q[SwW-1 -: REG_ADDR_W];
  assign sw_slice_s = sw_s2_q[SL_W:1];
  assign sw_mode_s  = sw_s2_q[0];

  logic btn_level, btn_rise;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_freeze),
    .level(btn_level),
    .rise (btn_rise)
  );

  // Rise and level are registered together, so level is always high with rise.
  logic freeze_edge;
  assign freeze_edge = btn_rise & btn_level;

  // Mode FSM.
  view_state_e state_q, state_d;
  logic        scroll_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StManual;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StManual: if (sw_mode_s)  state_d = StAuto;
      StAuto:   if (!sw_mode_s) state_d = StManual;
      default:  state_d = StManual;
    endcase
  end

  always_comb begin
    scroll_en = 1'b0;
    case (state_q)
      StAuto:  scroll_en = 1'b1;
      default: scroll_en = 1'b0;
    endcase
  end

  // Freeze and snapshot.
  logic              frozen_q, frozen_d;
  logic [DATA_W-1:0] snapshot_q, snapshot_d;

  always_comb begin
    frozen_d   = frozen_q;
    snapshot_d = snapshot_q;
    if (freeze_edge) begin
      frozen_d = ~frozen_q;
      // reg_data still belongs to the pre-step address even if a scroll step
      // lands on this same edge.
      if (!frozen_q) snapshot_d = reg_data;
    end
  end

  // Address / slice selection and prescaler.
  logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [SL_W-1:0]       slice_q, slice_d;
  logic [PrescW-1:0]     presc_q, presc_d;

  // frozen_d is used so a coinciding freeze edge takes effect before the step.
  always_comb begin
    presc_d    = '0;
    reg_addr_d = reg_addr_q;
    slice_d    = slice_q;
    if (scroll_en) begin
      if (presc_q == PrescMax) begin
        if (slice_q >= LastSlice) begin
          slice_d = '0;
          if (!frozen_d) reg_addr_d = reg_addr_q + REG_ADDR_W'(1);
        end else begin
          slice_d = slice_q + SL_W'(1);
        end
      end else begin
        presc_d = presc_q + PrescW'(1);
      end
    end else begin
      slice_d = sw_slice_s;
      if (!frozen_d) reg_addr_d = sw_reg_s;
    end
  end

  // LED slice mux; indices past the last slice show nothing.
  logic [PadW-1:0]  src_pad;
  logic [LED_W-1:0] leds_q, leds_d;

  assign src_pad = PadW'(frozen_q ? snapshot_q : reg_data);

  always_comb begin
    leds_d = '0;
    for (int unsigned i = 0; i < NUM_SLICES; i++) begin
      if (slice_q == SL_W'(i)) leds_d = src_pad[i*LED_W +: LED_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frozen_q   <= 1'b0;
      snapshot_q <= '0;
      reg_addr_q <= '0;
      slice_q    <= '0;
      presc_q    <= '0;
      leds_q     <= '0;
    end else begin
      frozen_q   <= frozen_d;
      snapshot_q <= snapshot_d;
      reg_addr_q <= reg_addr_d;
      slice_q    <= slice_d;
      presc_q    <= presc_d;
      leds_q     <= leds_d;
    end
  end

  assign reg_addr  = reg_addr_q;
  assign slice_idx = slice_q;
  assign leds      = leds_q;
  assign frozen    = frozen_q;

endmodule

// File: tb/tb_led_register_viewer.sv
// Scoreboard bench for led_register_viewer. Stimulus pushes expected outputs
// tagged with the clock-edge count at which they must hold; a negedge monitor
// pops and compares every entry due at the current edge count.
// Latencies below are counted from the first clock edge that samples a new
// input level: switches reach reg_addr/slice_idx after 2 sync edges + 1, leds
// one edge later; the button needs 2 sync edges + 3 debounce edges, then frozen.
module tb_led_register_viewer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT 0: 32-bit data, 2 slices.
  logic [3:0]  sw_reg0   = '0;
  logic        sw_slice0 = 1'b0;
  logic        sw_mode0  = 1'b0;
  logic        btn0      = 1'b0;
  logic [3:0]  addr0;
  logic [31:0] data0;
  logic [15:0] leds0;
  logic        frozen0;
  logic        slice0;
  logic [31:0] regs0 [16];
  assign data0 = regs0[addr0];

  led_register_viewer #(
    .DATA_W(32), .LED_W(16), .REG_ADDR_W(4), .SCROLL_DIV(4), .DEBOUNCE_CYCLES(3)
  ) u_dut0 (
    .clk(clk), .reset(reset), .sw_reg(sw_reg0), .sw_slice(sw_slice0), .sw_mode(sw_mode0),
    .btn_freeze(btn0), .reg_addr(addr0), .reg_data(data0), .leds(leds0),
    .frozen(frozen0), .slice_idx(slice0)
  );

  // DUT 1: 40-bit data, 3 slices, partial top slice.
  logic [3:0]  sw_reg1   = '0;
  logic [1:0]  sw_slice1 = '0;
  logic        sw_mode1  = 1'b0;
  logic        btn1      = 1'b0;
  logic [3:0]  addr1;
  logic [39:0] data1;
  logic [15:0] leds1;
  logic        frozen1;
  logic [1:0]  slice1;
  assign data1 = {4'hC, addr1, 32'h89AB_CDEF};

  led_register_viewer #(
    .DATA_W(40), .LED_W(16), .REG_ADDR_W(4), .SCROLL_DIV(4), .DEBOUNCE_CYCLES(3)
  ) u_dut1 (
    .clk(clk), .reset(reset), .sw_reg(sw_reg1), .sw_slice(sw_slice1), .sw_mode(sw_mode1),
    .btn_freeze(btn1), .reg_addr(addr1), .reg_data(data1), .leds(leds1),
    .frozen(frozen1), .slice_idx(slice1)
  );

  // Scoreboard. mask bits: [3] leds, [2] reg_addr, [1] slice_idx, [0] frozen.
  typedef struct {
    int unsigned cyc;
    int          dut;
    string       name;
    logic [3:0]  mask;
    logic [31:0] leds;
    logic [31:0] addr;
    logic [31:0] slice;
    logic [31:0] frozen;
  } exp_t;

  exp_t sb[$];
  exp_t keep[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic expect_at(input int unsigned at, input int dut, input string name,
                           input logic [3:0] mask, input logic [31:0] l,
                           input logic [31:0] a, input logic [31:0] s, input logic [31:0] f);
    exp_t e;
    e.cyc = at; e.dut = dut; e.name = name; e.mask = mask;
    e.leds = l; e.addr = a; e.slice = s; e.frozen = f;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s.%s @cyc %0d: got 0x%0h, want 0x%0h", name, field, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].cyc == cyc) begin
        if (sb[i].dut == 0) begin
          if (sb[i].mask[3]) cmp(sb[i].name, "leds", 32'(leds0), sb[i].leds);
          if (sb[i].mask[2]) cmp(sb[i].name, "reg_addr", 32'(addr0), sb[i].addr);
          if (sb[i].mask[1]) cmp(sb[i].name, "slice_idx", 32'(slice0), sb[i].slice);
          if (sb[i].mask[0]) cmp(sb[i].name, "frozen", 32'(frozen0), sb[i].frozen);
        end else begin
          if (sb[i].mask[3]) cmp(sb[i].name, "leds", 32'(leds1), sb[i].leds);
          if (sb[i].mask[2]) cmp(sb[i].name, "reg_addr", 32'(addr1), sb[i].addr);
          if (sb[i].mask[1]) cmp(sb[i].name, "slice_idx", 32'(slice1), sb[i].slice);
          if (sb[i].mask[0]) cmp(sb[i].name, "frozen", 32'(frozen1), sb[i].frozen);
        end
      end else if (sb[i].cyc < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s: expectation for cyc %0d never compared", sb[i].name, sb[i].cyc);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic wait_until(input int unsigned t);
    while (cyc < t) @(negedge clk);
  endtask

  int unsigned c, d, h, r;

  initial begin
    for (int i = 0; i < 16; i++) regs0[i] = 32'h1111_1111 * i;
    regs0[0]  = 32'h0123_4567;
    regs0[1]  = 32'h89AB_CDEF;
    regs0[3]  = 32'hDEAD_BEEF;
    regs0[15] = 32'hF00D_CAFE;

    // Reset state.
    repeat (3) @(negedge clk);
    expect_at(cyc + 1, 0, "rst0", 4'b1111, 0, 0, 0, 0);
    expect_at(cyc + 1, 1, "rst1", 4'b1111, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    c = cyc;
    expect_at(c + 1, 0, "init0", 4'b1111, 32'h4567, 0, 0, 0);
    expect_at(c + 1, 1, "init1", 4'b1000, 32'hCDEF, 0, 0, 0);

    // Wide word: middle, partial top and out-of-range slices.
    repeat (2) @(negedge clk);
    c = cyc; sw_slice1 = 2'd1;
    expect_at(c + 4, 1, "w40_s1", 4'b1010, 32'h89AB, 0, 1, 0);
    wait_until(c + 5);
    c = cyc; sw_slice1 = 2'd2;
    expect_at(c + 3, 1, "w40_s2_pre", 4'b1010, 32'h89AB, 0, 2, 0);
    expect_at(c + 4, 1, "w40_s2", 4'b1000, 32'h00C0, 0, 0, 0);
    wait_until(c + 5);
    c = cyc; sw_slice1 = 2'd3;
    expect_at(c + 3, 1, "w40_s3_pre", 4'b1010, 32'h00C0, 0, 3, 0);
    expect_at(c + 4, 1, "w40_s3", 4'b1000, 32'h0000, 0, 0, 0);
    wait_until(c + 5);

    // Manual selection latency.
    c = cyc; sw_reg0 = 4'd3; sw_slice0 = 1'b0;
    expect_at(c + 3, 0, "man_r3_pre", 4'b1100, 32'h4567, 3, 0, 0);
    expect_at(c + 4, 0, "man_r3", 4'b1000, 32'hBEEF, 0, 0, 0);
    wait_until(c + 5);
    c = cyc; sw_slice0 = 1'b1;
    expect_at(c + 3, 0, "man_s1_pre", 4'b1010, 32'hBEEF, 0, 1, 0);
    expect_at(c + 4, 0, "man_s1", 4'b1100, 32'hDEAD, 3, 0, 0);
    wait_until(c + 5);

    // Auto-scroll from reg 15 slice 1.
    c = cyc; sw_reg0 = 4'd15;
    expect_at(c + 4, 0, "man_r15", 4'b1110, 32'hF00D, 15, 1, 0);
    wait_until(c + 5);
    d = cyc; sw_mode0 = 1'b1;
    expect_at(d + 6, 0, "auto_hold", 4'b0110, 0, 15, 1, 0);
    expect_at(d + 7, 0, "auto_wrap", 4'b0110, 0, 0, 0, 0);
    expect_at(d + 8, 0, "auto_wrap_leds", 4'b1000, 32'h4567, 0, 0, 0);
    expect_at(d + 11, 0, "auto_step2", 4'b0110, 0, 0, 1, 0);
    expect_at(d + 12, 0, "auto_step2_leds", 4'b1000, 32'h0123, 0, 0, 0);
    expect_at(d + 15, 0, "auto_step3", 4'b0110, 0, 1, 0, 0);
    expect_at(d + 16, 0, "auto_step3_leds", 4'b1000, 32'hCDEF, 0, 0, 0);
    wait_until(d + 17);
    c = cyc; sw_mode0 = 1'b0;
    expect_at(c + 5, 0, "back_manual", 4'b0110, 0, 15, 1, 0);
    expect_at(c + 6, 0, "back_manual_leds", 4'b1000, 32'hF00D, 0, 0, 0);
    wait_until(c + 7);

    // Freeze: bounce must be ignored, then a stable press freezes.
    c = cyc; sw_reg0 = 4'd3; sw_slice0 = 1'b0; regs0[3] = 32'h1234_5678;
    wait_until(c + 6);
    for (int i = 0; i < 10; i++) begin
      btn0 = (i % 2 == 0);
      expect_at(cyc + 1, 0, "bounce", 4'b0001, 0, 0, 0, 0);
      @(negedge clk);
    end
    h = cyc; btn0 = 1'b1;
    expect_at(h + 5, 0, "freeze_pre", 4'b0001, 0, 0, 0, 0);
    expect_at(h + 6, 0, "freeze", 4'b0101, 0, 3, 0, 1);
    wait_until(h + 7);
    c = cyc; regs0[3] = 32'h0; sw_reg0 = 4'd5;
    expect_at(c + 2, 0, "frz_snap_lo", 4'b1001, 32'h5678, 0, 0, 1);
    expect_at(c + 5, 0, "frz_addr_hold", 4'b1100, 32'h5678, 3, 0, 0);
    wait_until(c + 6);
    c = cyc; sw_slice0 = 1'b1;
    expect_at(c + 4, 0, "frz_snap_hi", 4'b1111, 32'h1234, 3, 1, 1);
    wait_until(c + 5);

    // Auto-scroll while frozen: slices wrap, address holds.
    d = cyc; sw_mode0 = 1'b1;
    expect_at(d + 7, 0, "frz_auto_wrap", 4'b0110, 0, 3, 0, 0);
    expect_at(d + 8, 0, "frz_auto_lo", 4'b1000, 32'h5678, 0, 0, 0);
    expect_at(d + 11, 0, "frz_auto_step", 4'b0110, 0, 3, 1, 0);
    expect_at(d + 12, 0, "frz_auto_hi", 4'b1000, 32'h1234, 0, 0, 0);
    expect_at(d + 15, 0, "frz_auto_wrap2", 4'b0111, 0, 3, 0, 1);
    wait_until(d + 17);

    // Asynchronous reset mid-scroll while frozen.
    @(posedge clk);
    #2;
    reset = 1'b0;
    btn0 = 1'b0; sw_mode0 = 1'b0; sw_reg0 = 4'd2; sw_slice0 = 1'b1;
    expect_at(cyc, 0, "async_rst", 4'b1111, 0, 0, 0, 0);
    expect_at(cyc, 1, "async_rst1", 4'b1000, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    r = cyc;
    expect_at(r + 1, 0, "post_rst", 4'b1111, 32'h4567, 0, 0, 0);
    expect_at(r + 2, 0, "post_rst_sync", 4'b0110, 0, 0, 0, 0);
    expect_at(r + 3, 0, "post_rst_sel", 4'b0110, 0, 2, 1, 0);
    expect_at(r + 4, 0, "post_rst_leds", 4'b1000, 32'h2222, 0, 0, 0);
    expect_at(r + 9, 0, "post_rst_manual", 4'b1111, 32'h2222, 2, 1, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
